stable_matching_checker: RTL and testbench

- Sequential stability verifier sitting directly downstream of stable_matching_comb.
- Snapshots the same packed preference vector fed to the matcher, plus the match list it produced.
- Validates the matching: every pair must be mutually acceptable and no s may be matched twice.
- Then scans every (r, preference slot) candidate, one per cycle, for a blocking pair.
- Reports stable / blocking pair / invalid matching, with the offending indices.

---
 rtl/stable_matching_checker.sv | 260 ++++++++++++++++++++++++++
 tb/tb_stable_matching_checker.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stable_matching_checker.sv
// Sequential stability verifier for a stable_matching_comb result: validates the
// match list, then scans (r, slot) candidates one per cycle for a blocking pair.
module stable_matching_checker #(
  parameter int Kr = 2,
  parameter int Ks = 2,
  parameter int S  = 3,
  parameter int R  = 3,
  localparam int logS = (S > 1) ? $clog2(S) : 1,
  localparam int logR = (R > 1) ? $clog2(R) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [(R*Kr+S*Ks)*logS-1:0]     pref_in,
  input  logic [R*logS-1:0]               match_in,
  input  logic [R-1:0]                    r_matched,
  output logic                            busy,
  output logic                            done,
  output logic [1:0]                      status,
  output logic [logR-1:0]                 blk_r,
  output logic [logS-1:0]                 blk_s
);

  localparam int NP    = R*Kr + S*Ks;
  localparam int logKr = (Kr > 1) ? $clog2(Kr) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] VALIDATE = 2'd1;
  localparam logic [1:0] SCAN     = 2'd2;

  localparam logic [1:0] ST_STABLE   = 2'd0;
  localparam logic [1:0] ST_BLOCKING = 2'd1;
  localparam logic [1:0] ST_INVALID  = 2'd2;

  logic [1:0]           state_q,    state_d;
  logic [NP*logS-1:0]   pref_q,     pref_d;
  logic [R*logS-1:0]    match_q,    match_d;
  logic [R-1:0]         rmatched_q, rmatched_d;
  logic [logR-1:0]      r_q,        r_d;
  logic [logKr-1:0]     k_q,        k_d;
  logic                 reached_q,  reached_d;
  logic                 fail_q,     fail_d;
  logic [logR-1:0]      fail_r_q,   fail_r_d;
  logic                 done_q,     done_d;
  logic [1:0]           status_q,   status_d;
  logic [logR-1:0]      blk_r_q,    blk_r_d;
  logic [logS-1:0]      blk_s_q,    blk_s_d;

  logic [logS-1:0] rpref [R][Kr];
  logic [logS-1:0] spref [S][Ks];
  logic [logS-1:0] match [R];

  for (genvar gi = 0; gi < R; gi++) begin : g_r
    assign match[gi] = match_q[logS*gi +: logS];
    for (genvar gk = 0; gk < Kr; gk++) begin : g_rk
      assign rpref[gi][gk] = pref_q[logS*(gi*Kr+gk) +: logS];
    end
  end

  for (genvar gs = 0; gs < S; gs++) begin : g_s
    for (genvar gk = 0; gk < Ks; gk++) begin : g_sk
      assign spref[gs][gk] = pref_q[logS*(R*Kr+gs*Ks+gk) +: logS];
    end
  end

  // Validation: lowest matched r whose pair is not mutually acceptable or whose s repeats.
  logic            v_fail;
  logic [logR-1:0] v_r;
  logic            in_r, in_s, dup;

  always_comb begin
    v_fail = 1'b0;
    v_r    = '0;
    in_r   = 1'b0;
    in_s   = 1'b0;
    dup    = 1'b0;
    for (int i = 0; i < R; i++) begin
      in_r = 1'b0;
      in_s = 1'b0;
      dup  = 1'b0;
      for (int kk = 0; kk < Kr; kk++)
        if (rpref[i][kk] == match[i]) in_r = 1'b1;
      for (int j = 0; j < S; j++)
        if (match[i] == logS'(j))
          for (int kk = 0; kk < Ks; kk++)
            if (spref[j][kk] == logS'(i)) in_s = 1'b1;
      for (int j = 0; j < R; j++)
        if (j < i && rmatched_q[j] && match[j] == match[i]) dup = 1'b1;
      if (rmatched_q[i] && !v_fail && (!in_r || !in_s || dup)) begin
        v_fail = 1'b1;
        v_r    = logR'(i);
      end
    end
  end

  // Candidate evaluation for the current (r, k) scan position.
  logic [logS-1:0] cand_s, my_match, p_idx, fail_s;
  logic            my_matched, found_r, has_p, found_p, is_own, blocking;
  int              rank_r, rank_p;

  always_comb begin
    cand_s     = '0;
    my_match   = '0;
    my_matched = 1'b0;
    fail_s     = '0;
    for (int i = 0; i < R; i++) begin
      if (r_q == logR'(i)) begin
        my_match   = match[i];
        my_matched = rmatched_q[i];
        for (int kk = 0; kk < Kr; kk++)
          if (k_q == logKr'(kk)) cand_s = rpref[i][kk];
      end
      if (fail_r_q == logR'(i)) fail_s = match[i];
    end

    found_r = 1'b0;
    rank_r  = 0;
    for (int j = 0; j < S; j++)
      if (cand_s == logS'(j))
        for (int kk = 0; kk < Ks; kk++)
          if (!found_r && spref[j][kk] == logS'(r_q)) begin
            found_r = 1'b1;
            rank_r  = kk;
          end

    has_p = 1'b0;
    p_idx = '0;
    for (int i = 0; i < R; i++)
      if (!has_p && rmatched_q[i] && match[i] == cand_s) begin
        has_p = 1'b1;
        p_idx = logS'(i);
      end

    found_p = 1'b0;
    rank_p  = 0;
    for (int j = 0; j < S; j++)
      if (cand_s == logS'(j))
        for (int kk = 0; kk < Ks; kk++)
          if (!found_p && spref[j][kk] == p_idx) begin
            found_p = 1'b1;
            rank_p  = kk;
          end

    is_own   = my_matched && (cand_s == my_match);
    blocking = found_r && (!has_p || (found_p && rank_r < rank_p));
  end

  always_comb begin
    state_d    = state_q;
    pref_d     = pref_q;
    match_d    = match_q;
    rmatched_d = rmatched_q;
    r_d        = r_q;
    k_d        = k_q;
    reached_d  = reached_q;
    fail_d     = fail_q;
    fail_r_d   = fail_r_q;
    done_d     = 1'b0;
    status_d   = status_q;
    blk_r_d    = blk_r_q;
    blk_s_d    = blk_s_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          pref_d     = pref_in;
          match_d    = match_in;
          rmatched_d = r_matched;
          status_d   = ST_STABLE;
          blk_r_d    = '0;
          blk_s_d    = '0;
          state_d    = VALIDATE;
        end
      end
      VALIDATE: begin
        fail_d    = v_fail;
        fail_r_d  = v_r;
        r_d       = '0;
        k_d       = '0;
        reached_d = 1'b0;
        state_d   = SCAN;
      end
      SCAN: begin
        // An invalid matching is reported in the first scan slot so it shares
        // the same two-edge latency as a block found at candidate 0.
        if (fail_q) begin
          status_d = ST_INVALID;
          blk_r_d  = fail_r_q;
          blk_s_d  = fail_s;
          done_d   = 1'b1;
          fail_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          if (!reached_q && is_own) reached_d = 1'b1;
          if (!reached_q && !is_own && blocking) begin
            status_d = ST_BLOCKING;
            blk_r_d  = r_q;
            blk_s_d  = cand_s;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else if (k_q == logKr'(Kr-1)) begin
            k_d       = '0;
            reached_d = 1'b0;
            if (r_q == logR'(R-1)) begin
              status_d = ST_STABLE;
              blk_r_d  = '0;
              blk_s_d  = '0;
              done_d   = 1'b1;
              state_d  = IDLE;
            end else begin
              r_d = r_q + logR'(1);
            end
          end else begin
            k_d = k_q + logKr'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pref_q     <= '0;
      match_q    <= '0;
      rmatched_q <= '0;
      r_q        <= '0;
      k_q        <= '0;
      reached_q  <= 1'b0;
      fail_q     <= 1'b0;
      fail_r_q   <= '0;
      done_q     <= 1'b0;
      status_q   <= '0;
      blk_r_q    <= '0;
      blk_s_q    <= '0;
    end else begin
      state_q    <= state_d;
      pref_q     <= pref_d;
      match_q    <= match_d;
      rmatched_q <= rmatched_d;
      r_q        <= r_d;
      k_q        <= k_d;
      reached_q  <= reached_d;
      fail_q     <= fail_d;
      fail_r_q   <= fail_r_d;
      done_q     <= done_d;
      status_q   <= status_d;
      blk_r_q    <= blk_r_d;
      blk_s_q    <= blk_s_d;
    end
  end

  assign busy   = (state_q == VALIDATE) || (state_q == SCAN);
  assign done   = done_q;
  assign status = status_q;
  assign blk_r  = blk_r_q;
  assign blk_s  = blk_s_q;

endmodule

// File: tb/tb_stable_matching_checker.sv
// Bench for stable_matching_checker: directed test-plan scenarios plus randomized
// matchings compared against a list-based reference model.
module tb_stable_matching_checker;

  localparam int Kr = 2, Ks = 2, S = 3, R = 3;
  localparam int logS = 2, logR = 2;
  localparam int NP = R*Kr + S*Ks;

  logic                 clk = 1'b0;
  logic                 rst, start;
  logic [NP*logS-1:0]   pref_in;
  logic [R*logS-1:0]    match_in;
  logic [R-1:0]         r_matched;
  logic                 busy, done;
  logic [1:0]           status;
  logic [logR-1:0]      blk_r;
  logic [logS-1:0]      blk_s;

  int total = 0;
  int bad   = 0;

  int rp [R][Kr];
  int sp [S][Ks];
  int mt [R];
  bit mm [R];

  stable_matching_checker #(.Kr(Kr), .Ks(Ks), .S(S), .R(R)) dut (
    .clk(clk), .rst(rst), .start(start), .pref_in(pref_in), .match_in(match_in),
    .r_matched(r_matched), .busy(busy), .done(done), .status(status),
    .blk_r(blk_r), .blk_s(blk_s)
  );

  always #5 clk = ~clk;

  function automatic int rank_of(int s, int x);
    for (int k = 0; k < Ks; k++) if (sp[s][k] == x) return k;
    return -1;
  endfunction

  // Reference: validation first, then each r walks its list until its own partner.
  function automatic void model(output int st, output int br, output int bs, output int lt);
    bit ok_r, ok_s, dp;
    int s, rr, p;
    st = 0; br = 0; bs = 0; lt = R*Kr + 1;
    for (int r = 0; r < R; r++) begin
      if (!mm[r]) continue;
      ok_r = 0; ok_s = 0; dp = 0;
      for (int k = 0; k < Kr; k++) if (rp[r][k] == mt[r]) ok_r = 1;
      if (rank_of(mt[r], r) >= 0) ok_s = 1;
      for (int r2 = 0; r2 < r; r2++) if (mm[r2] && mt[r2] == mt[r]) dp = 1;
      if (!ok_r || !ok_s || dp) begin
        st = 2; br = r; bs = mt[r]; lt = 2;
        return;
      end
    end
    for (int r = 0; r < R; r++) begin
      for (int k = 0; k < Kr; k++) begin
        s = rp[r][k];
        if (mm[r] && s == mt[r]) break;
        rr = rank_of(s, r);
        if (rr < 0) continue;
        p = -1;
        for (int r2 = 0; r2 < R; r2++) if (mm[r2] && mt[r2] == s) p = r2;
        if (p < 0 || rr < rank_of(s, p)) begin
          st = 1; br = r; bs = s; lt = r*Kr + k + 2;
          return;
        end
      end
    end
  endfunction

  task automatic pack_inputs();
    for (int r = 0; r < R; r++) begin
      for (int k = 0; k < Kr; k++) pref_in[logS*(r*Kr+k) +: logS] = logS'(rp[r][k]);
      match_in[logS*r +: logS] = logS'(mt[r]);
      r_matched[r] = mm[r];
    end
    for (int s = 0; s < S; s++)
      for (int k = 0; k < Ks; k++) pref_in[logS*(R*Kr+s*Ks+k) +: logS] = logS'(sp[s][k]);
  endtask

  task automatic set_common_prefs();
    rp = '{'{0, 1}, '{1, 2}, '{2, 0}};
    sp = '{'{0, 2}, '{1, 0}, '{2, 1}};
  endtask

  task automatic set_match(input int m0, input int m1, input int m2, input bit [2:0] mb);
    mt[0] = m0; mt[1] = m1; mt[2] = m2;
    mm[0] = mb[0]; mm[1] = mb[1]; mm[2] = mb[2];
  endtask

  // Pulses start for one edge, then counts edges until done (-1 on timeout).
  task automatic applyStimulus(output int lat);
    pack_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0)   begin bad++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
    total++; if (status !== 2'd0) begin bad++; $display("[TB] FAIL reset_status: got %0d want 0", status); end
    total++; if (blk_r !== 2'd0)  begin bad++; $display("[TB] FAIL reset_blk_r: got %0d want 0", blk_r); end
    total++; if (blk_s !== 2'd0)  begin bad++; $display("[TB] FAIL reset_blk_s: got %0d want 0", blk_s); end
    rst = 1'b0;
  endtask

  task automatic test_directed(input string nm, input int m0, input int m1, input int m2,
                               input bit [2:0] mb, input int e_lat, input int e_st,
                               input int e_br, input int e_bs);
    int lat;
    set_common_prefs();
    set_match(m0, m1, m2, mb);
    @(negedge clk);
    applyStimulus(lat);
    total++; if (lat != e_lat)      begin bad++; $display("[TB] FAIL %s_latency: got %0d want %0d", nm, lat, e_lat); end
    total++; if (status !== 2'(e_st)) begin bad++; $display("[TB] FAIL %s_status: got %0d want %0d", nm, status, e_st); end
    total++; if (blk_r !== 2'(e_br))  begin bad++; $display("[TB] FAIL %s_blk_r: got %0d want %0d", nm, blk_r, e_br); end
    total++; if (blk_s !== 2'(e_bs))  begin bad++; $display("[TB] FAIL %s_blk_s: got %0d want %0d", nm, blk_s, e_bs); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0)     begin bad++; $display("[TB] FAIL %s_done_pulse: got %0b want 0", nm, done); end
  endtask

  task automatic test_reset_abort();
    bit seen;
    set_common_prefs();
    set_match(0, 1, 2, 3'b111);
    @(negedge clk);
    pack_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (busy !== 1'b0)   begin bad++; $display("[TB] FAIL abort_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("[TB] FAIL abort_done: got %0b want 0", done); end
    total++; if (status !== 2'd0) begin bad++; $display("[TB] FAIL abort_status: got %0d want 0", status); end
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    total++; if (seen) begin bad++; $display("[TB] FAIL abort_no_done: got done pulse want none"); end
  endtask

  task automatic test_ignored_start();
    int lat;
    set_common_prefs();
    set_match(0, 1, 2, 3'b111);
    @(negedge clk);
    pack_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      if (n == 1) begin
        set_match(0, 0, 2, 3'b111);
        pack_inputs();
        start = 1'b1;
      end
      if (n == 3) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    total++; if (lat != 7)        begin bad++; $display("[TB] FAIL ignore_latency: got %0d want 7", lat); end
    total++; if (status !== 2'd0) begin bad++; $display("[TB] FAIL ignore_status: got %0d want 0", status); end
    total++; if (blk_r !== 2'd0)  begin bad++; $display("[TB] FAIL ignore_blk_r: got %0d want 0", blk_r); end
  endtask

  task automatic test_back_to_back();
    int lat;
    set_common_prefs();
    set_match(1, 2, 0, 3'b111);
    @(negedge clk);
    applyStimulus(lat);
    total++; if (lat != 2)        begin bad++; $display("[TB] FAIL b2b_first_latency: got %0d want 2", lat); end
    total++; if (status !== 2'd1) begin bad++; $display("[TB] FAIL b2b_first_status: got %0d want 1", status); end
    set_match(0, 1, 2, 3'b111);
    pack_inputs();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1)   begin bad++; $display("[TB] FAIL b2b_busy: got %0b want 1", busy); end
    total++; if (status !== 2'd0) begin bad++; $display("[TB] FAIL b2b_cleared: got %0d want 0", status); end
    lat = -1;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    total++; if (lat != 7)        begin bad++; $display("[TB] FAIL b2b_second_latency: got %0d want 7", lat); end
    total++; if (status !== 2'd0) begin bad++; $display("[TB] FAIL b2b_second_status: got %0d want 0", status); end
  endtask

  task automatic test_random(input int trials);
    int perm [S];
    int mode, j, tmp, lat, e_st, e_br, e_bs, e_lt;
    for (int t = 0; t < trials; t++) begin
      for (int r = 0; r < R; r++) for (int k = 0; k < Kr; k++) rp[r][k] = $urandom_range(S-1);
      for (int s = 0; s < S; s++) for (int k = 0; k < Ks; k++) sp[s][k] = $urandom_range(R-1);
      mode = $urandom_range(2);
      for (int i = 0; i < S; i++) perm[i] = i;
      for (int i = S-1; i > 0; i--) begin
        j = $urandom_range(i);
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int r = 0; r < R; r++) begin
        if (mode == 0) begin
          mt[r] = $urandom_range(S-1);
          mm[r] = 1'($urandom_range(1));
        end else begin
          mt[r] = perm[r];
          mm[r] = (mode == 2) ? 1'($urandom_range(1)) : 1'b1;
          if (mm[r]) begin
            rp[r][$urandom_range(Kr-1)] = mt[r];
            sp[mt[r]][$urandom_range(Ks-1)] = r;
          end
        end
      end
      model(e_st, e_br, e_bs, e_lt);
      @(negedge clk);
      applyStimulus(lat);
      total++; if (lat != e_lt)        begin bad++; $display("[TB] FAIL rand%0d_latency: got %0d want %0d", t, lat, e_lt); end
      total++; if (status !== 2'(e_st)) begin bad++; $display("[TB] FAIL rand%0d_status: got %0d want %0d", t, status, e_st); end
      total++; if (blk_r !== 2'(e_br))  begin bad++; $display("[TB] FAIL rand%0d_blk_r: got %0d want %0d", t, blk_r, e_br); end
      total++; if (blk_s !== 2'(e_bs))  begin bad++; $display("[TB] FAIL rand%0d_blk_s: got %0d want %0d", t, blk_s, e_bs); end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pref_in = '0;
    match_in = '0;
    r_matched = '0;
    test_reset();
    test_directed("stable",    0, 1, 2, 3'b111, 7, 0, 0, 0);
    test_directed("blocking",  1, 2, 0, 3'b111, 2, 1, 0, 0);
    test_directed("duplicate", 0, 0, 2, 3'b111, 2, 2, 1, 0);
    test_directed("unmatched", 0, 1, 1, 3'b011, 6, 1, 2, 2);
    test_reset_abort();
    test_ignored_start();
    test_back_to_back();
    test_random(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
